// File: rtl/i2c_sccb_responder_pkg.sv
// Shared definitions for the SCCB/I2C register-map responder: FSM states, ACK/NACK bit levels,
// default device address and the register-window hit test.
package i2c_sccb_responder_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDev,
        StAckDev,
        StRegH,
        StAckH,
        StRegL,
        StAckL,
        StWdata,
        StAckW,
        StRdata,
        StRack,
        StIgnore
    } state_e;

    localparam logic       ACK_BIT      = 1'b0;
    localparam logic       NACK_BIT     = 1'b1;
    localparam logic [7:0] DEF_DEV_ADDR = 8'h78;

    // True when addr lies in [base, base + 2^aw - 1]; the subtraction wraps modulo 2^16.
    function automatic logic win_hit(input logic [15:0] addr, input logic [15:0] base,
                                     input int unsigned aw);
        logic [15:0] off;
        off = addr - base;
        return ({16'h0, off} >> aw) == 32'h0;
    endfunction

endpackage

// File: rtl/i2c_sccb_responder_line_filter.sv
// Two-flop synchronizer followed by a stability filter; emits one-clk rise/fall pulses that are
// aligned with the filtered level update.
module i2c_sccb_responder_line_filter #(
    parameter int unsigned FILT_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned CW = $clog2(FILT_CYC + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[0], line_i};
        cnt_d  = '0;
        filt_d = filt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Any bounce back to the accepted level restarts the hold count.
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILT_CYC - 1)) begin
                filt_d = sync_q[1];
                rise_d = sync_q[1];
                fall_d = !sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = filt_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_sccb_responder.sv
// I2C/SCCB target modelling a camera sensor with a 16-bit register address space; a window of
// the map is backed by storage and every accepted write is reported on the wr_* strobe.
module i2c_sccb_responder
    import i2c_sccb_responder_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR = DEF_DEV_ADDR,
    parameter logic [15:0] WIN_BASE = 16'h3000,
    parameter int unsigned WIN_AW   = 10,
    parameter int unsigned FILT_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    output logic        busy,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_valid
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sccb_responder_line_filter #(.FILT_CYC(FILT_CYC)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (i2c_scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_sccb_responder_line_filter #(.FILT_CYC(FILT_CYC)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (i2c_sda),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall && scl_lvl;
    assign stop_det  = sda_rise && scl_lvl;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  regh_q, regh_d;
    logic [15:0] reg_ptr_q, reg_ptr_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        wr_valid_q, wr_valid_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        mem_we;

    logic [7:0]  mem_q [2**WIN_AW];
    logic [15:0] rd_ptr;
    logic [7:0]  rd_byte;

    // The RACK reload fetches the byte after the one just shifted out.
    assign rd_ptr  = (state_q == StRack) ? reg_ptr_q + 16'd1 : reg_ptr_q;
    assign rd_byte = win_hit(rd_ptr, WIN_BASE, WIN_AW) ? mem_q[WIN_AW'(rd_ptr - WIN_BASE)]
                                                       : 8'hFF;

    logic rx_state, byte_done;
    assign rx_state  = (state_q == StDev) || (state_q == StRegH) ||
                       (state_q == StRegL) || (state_q == StWdata);
    assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        regh_d     = regh_q;
        reg_ptr_d  = reg_ptr_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = StDev;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            if (rx_state && scl_rise && bit_cnt_q != 4'd8) begin
                shreg_d   = {shreg_q[6:0], sda_lvl};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            unique case (state_q)
                StDev: if (byte_done) begin
                    if (shreg_q[7:1] == DEV_ADDR[7:1]) begin
                        state_d  = StAckDev;
                        rw_d     = shreg_q[0];
                        busy_d   = 1'b1;
                        sda_oe_d = ~ACK_BIT;
                    end else begin
                        state_d  = StIgnore;
                        busy_d   = 1'b0;
                        sda_oe_d = 1'b0;
                    end
                end
                StAckDev: if (scl_fall) begin
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        state_d    = StRdata;
                        shreg_d    = rd_byte;
                        sda_oe_d   = ~rd_byte[7];
                        rd_valid_d = 1'b1;
                    end else begin
                        state_d  = StRegH;
                        sda_oe_d = 1'b0;
                    end
                end
                StRegH: if (byte_done) begin
                    state_d  = StAckH;
                    regh_d   = shreg_q;
                    sda_oe_d = ~ACK_BIT;
                end
                StRegL: if (byte_done) begin
                    state_d   = StAckL;
                    reg_ptr_d = {regh_q, shreg_q};
                    sda_oe_d  = ~ACK_BIT;
                end
                StAckH, StAckL, StAckW: if (scl_fall) begin
                    state_d   = (state_q == StAckH) ? StRegL : StWdata;
                    bit_cnt_d = '0;
                    sda_oe_d  = 1'b0;
                end
                StWdata: if (byte_done) begin
                    if (win_hit(reg_ptr_q, WIN_BASE, WIN_AW)) begin
                        state_d    = StAckW;
                        mem_we     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = reg_ptr_q;
                        wr_data_d  = shreg_q;
                        reg_ptr_d  = reg_ptr_q + 16'd1;
                        sda_oe_d   = ~ACK_BIT;
                    end else begin
                        state_d  = StIgnore;
                        busy_d   = 1'b0;
                        sda_oe_d = ~NACK_BIT;
                    end
                end
                StRdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        state_d  = StRack;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        sda_oe_d = ~shreg_q[6];
                    end
                end
                StRack: begin
                    if (scl_rise) begin
                        mack_d = sda_lvl;
                    end else if (scl_fall) begin
                        if (mack_q == ACK_BIT) begin
                            state_d    = StRdata;
                            reg_ptr_d  = reg_ptr_q + 16'd1;
                            bit_cnt_d  = '0;
                            shreg_d    = rd_byte;
                            sda_oe_d   = ~rd_byte[7];
                            rd_valid_d = 1'b1;
                        end else begin
                            state_d  = StIgnore;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            regh_q     <= '0;
            reg_ptr_q  <= '0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            regh_q     <= regh_d;
            reg_ptr_q  <= reg_ptr_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage survives reset on purpose.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[WIN_AW'(reg_ptr_q - WIN_BASE)] <= shreg_q;
        end
    end

    // A STOP seen during our ACK drive releases the line without waiting for the register.
    assign i2c_sda  = (sda_oe_q && !stop_det) ? 1'b0 : 1'bz;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_i2c_sccb_responder.sv
// Bench for i2c_sccb_responder: a bit-level bus master with a register-map model that predicts
// ACKs, write strobes and read data.
module tb_i2c_sccb_responder;
    localparam int  Q   = 12;          // clk cycles per SCL quarter period
    localparam time QNS = Q * 10;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    wire         i2c_sda;
    logic        busy, wr_valid, rd_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    logic [23:0] last_wr = '0;

    logic [7:0]  model_mem [logic [15:0]];
    logic [23:0] exp_wr_q [$];
    logic [7:0]  wq [$];
    logic [7:0]  rdbuf [$];

    always #5 clk = ~clk;

    assign i2c_sda = sda_m ? 1'bz : 1'b0;
    pullup (i2c_sda);

    i2c_sccb_responder #(
        .DEV_ADDR(8'h78),
        .WIN_BASE(16'h3000),
        .WIN_AW  (10),
        .FILT_CYC(3)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i2c_scl (scl_m),
        .i2c_sda (i2c_sda),
        .busy    (busy),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_valid(rd_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return (a >= 16'h3000) && (a <= 16'h33FF);
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (!in_win(a)) return 8'hFF;
        return model_mem.exists(a) ? model_mem[a] : 8'hxx;
    endfunction

    // Every strobe must match the next predicted write, in order.
    always @(negedge clk) begin
        if (!rst && (wr_valid || rd_valid)) check("wr_rd_exclusive", 32'(wr_valid & rd_valid), 0);
        if (!rst && wr_valid) begin
            wr_cnt++;
            last_wr = {wr_addr, wr_data};
            if (exp_wr_q.size() == 0) check("unexpected_wr", {8'h0, wr_addr, wr_data}, 32'hFFFFFFFF);
            else check("wr_event", {8'h0, wr_addr, wr_data}, {8'h0, exp_wr_q.pop_front()});
        end
        if (!rst && rd_valid) rd_cnt++;
    end

    task automatic bus_start();
        sda_m = 1'b1; #QNS; scl_m = 1'b1; #QNS; sda_m = 1'b0; #QNS; scl_m = 1'b0; #QNS;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #QNS; scl_m = 1'b1; #QNS; sda_m = 1'b1; #QNS; #QNS;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #QNS; scl_m = 1'b1; #(2 * QNS); scl_m = 1'b0; #QNS;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #QNS; scl_m = 1'b1; #QNS; b = i2c_sda; #QNS; scl_m = 1'b0; #QNS;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        put_bit(mack);
    endtask

    task automatic addr_phase(input logic [15:0] addr, input string tag);
        logic ack;
        bus_start();
        put_byte(8'h78, ack);       check({tag, "_dev_ack"}, 32'(ack), 0);
        put_byte(addr[15:8], ack);  check({tag, "_regh_ack"}, 32'(ack), 0);
        put_byte(addr[7:0], ack);   check({tag, "_regl_ack"}, 32'(ack), 0);
        check({tag, "_busy_hi"}, 32'(busy), 1);
    endtask

    task automatic txn_write(input logic [15:0] addr, input string tag);
        logic ack;
        logic [15:0] p;
        bit hit;
        p = addr;
        addr_phase(addr, tag);
        foreach (wq[i]) begin
            hit = in_win(p);
            if (hit) begin
                exp_wr_q.push_back({p, wq[i]});
                model_mem[p] = wq[i];
            end
            put_byte(wq[i], ack);
            check({tag, "_data_ack"}, 32'(ack), hit ? 0 : 1);
            if (!hit) break;
            p++;
        end
        bus_stop();
        check({tag, "_busy_lo"}, 32'(busy), 0);
    endtask

    task automatic txn_read(input logic [15:0] addr, input int n, input string tag);
        logic ack;
        logic [7:0] d;
        logic [15:0] p;
        int rd0;
        p = addr;
        rdbuf.delete();
        addr_phase(addr, tag);
        bus_start();
        rd0 = rd_cnt;
        put_byte(8'h79, ack);
        check({tag, "_rdev_ack"}, 32'(ack), 0);
        for (int k = 0; k < n; k++) begin
            get_byte((k == n - 1) ? 1'b1 : 1'b0, d);
            check({tag, "_rdata"}, 32'(d), 32'(model_rd(p)));
            rdbuf.push_back(d);
            p++;
        end
        bus_stop();
        check({tag, "_rd_valid_cnt"}, 32'(rd_cnt - rd0), 32'(n));
        check({tag, "_busy_lo"}, 32'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        logic [7:0] b30;
        int wr0;
        bit seen;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_sda", 32'(i2c_sda), 1);
        #QNS;

        // Single write.
        wr0 = wr_cnt;
        wq.delete(); wq.push_back(8'h82);
        txn_write(16'h3008, "t2");
        check("t2_wr_cnt", 32'(wr_cnt - wr0), 1);
        check("t2_wr_lit", 32'(last_wr), 32'h300882);

        // Burst write then SCCB-style combined read.
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        txn_write(16'h300A, "t3w");
        txn_read(16'h300A, 3, "t3r");
        check("t3_lit0", 32'(rdbuf[0]), 32'h11);
        check("t3_lit1", 32'(rdbuf[1]), 32'h22);
        check("t3_lit2", 32'(rdbuf[2]), 32'h33);

        // Foreign device address.
        wr0 = wr_cnt;
        bus_start();
        put_byte(8'h42, ack); check("t4_dev_nack", 32'(ack), 1);
        check("t4_busy", 32'(busy), 0);
        put_byte(8'h30, ack); check("t4_b1_nack", 32'(ack), 1);
        put_byte(8'h08, ack); check("t4_b2_nack", 32'(ack), 1);
        put_byte(8'h55, ack); check("t4_b3_nack", 32'(ack), 1);
        bus_stop();
        check("t4_no_wr", 32'(wr_cnt - wr0), 0);

        // Out-of-window write and read.
        wr0 = wr_cnt;
        wq.delete(); wq.push_back(8'h77);
        txn_write(16'h5000, "t5w");
        check("t5_no_wr", 32'(wr_cnt - wr0), 0);
        txn_read(16'h5000, 1, "t5r");
        check("t5_lit_ff", 32'(rdbuf[0]), 32'hFF);

        // Reset pulse during the ACK slot of the second byte.
        bus_start();
        put_byte(8'h78, ack); check("t6_dev_ack", 32'(ack), 0);
        b30 = 8'h30;
        for (int i = 7; i >= 0; i--) put_bit(b30[i]);
        sda_m = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4 * Q && !seen; c++) begin
            @(negedge clk);
            if (i2c_sda === 1'b0) seen = 1'b1;
        end
        check("t6_ack_driven", 32'(seen), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_sda_released", 32'(i2c_sda), 1);
        #QNS; scl_m = 1'b1; #(2 * QNS); scl_m = 1'b0; #QNS;
        bus_stop();
        check("t6_busy", 32'(busy), 0);
        txn_read(16'h3008, 1, "t6r1");
        check("t6_lit_82", 32'(rdbuf[0]), 32'h82);
        wq.delete(); wq.push_back(8'h5A);
        txn_write(16'h3008, "t6w");
        txn_read(16'h3008, 1, "t6r2");
        check("t6_lit_5a", 32'(rdbuf[0]), 32'h5A);

        check("pending_wr_empty", 32'(exp_wr_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
